// File: rtl/dma_copy.sv
// Byte-block copy/fill engine driving a single-port memory with combinational read.
// Copies use memmove semantics: a destination overlapping the source tail is walked backwards.
module dma_copy #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_start,
    input  logic          i_fill,
    input  logic [AW-1:0] i_src,
    input  logic [AW-1:0] i_dst,
    input  logic [AW-1:0] i_len,
    input  logic [DW-1:0] i_fill_val,
    input  logic          i_abort,
    input  logic [DW-1:0] i_mem_rdata,
    output logic [AW-1:0] o_mem_addr,
    output logic          o_mem_wr_en,
    output logic [DW-1:0] o_mem_wdata,
    output logic          o_busy,
    output logic          o_done
);

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_FIN} state_t;

    state_t        r_state;
    logic          r_fill;
    logic          r_dir;
    logic [AW-1:0] r_src;
    logic [AW-1:0] r_dst;
    logic [AW-1:0] r_len;
    logic [AW-1:0] r_i;
    logic [DW-1:0] r_fill_val;
    logic [DW-1:0] r_hold;

    logic [AW-1:0] w_off;
    logic [AW-1:0] w_gap;
    logic          w_dir;
    logic          w_last;

    // Destination lands inside the source tail: walk from the top so no source byte is clobbered early.
    assign w_gap  = i_dst - i_src;
    assign w_dir  = !i_fill && (i_dst != i_src) && (w_gap < i_len);
    assign w_off  = r_dir ? (r_len - AW'(1) - r_i) : r_i;
    assign w_last = (r_i == r_len - AW'(1));

    // NOTE: state registers use non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_fill     <= 1'b0;
            r_dir      <= 1'b0;
            r_src      <= '0;
            r_dst      <= '0;
            r_len      <= '0;
            r_i        <= '0;
            r_fill_val <= '0;
            r_hold     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        if (i_len == '0) begin
                            r_state <= S_FIN;
                        end else begin
                            r_fill     <= i_fill;
                            r_src      <= i_src;
                            r_dst      <= i_dst;
                            r_len      <= i_len;
                            r_fill_val <= i_fill_val;
                            r_dir      <= w_dir;
                            r_i        <= '0;
                            r_state    <= i_fill ? S_WR : S_RD;
                        end
                    end
                end
                S_RD: begin
                    r_hold  <= i_mem_rdata;
                    r_state <= i_abort ? S_IDLE : S_WR;
                end
                S_WR: begin
                    if (i_abort) begin
                        r_state <= S_IDLE;
                    end else if (w_last) begin
                        r_state <= S_FIN;
                    end else begin
                        r_i     <= r_i + AW'(1);
                        r_state <= r_fill ? S_WR : S_RD;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // NOTE: every output gets a default first, so no path through the case can infer a latch.
    always_comb begin
        o_mem_addr  = '0;
        o_mem_wr_en = 1'b0;
        o_mem_wdata = '0;
        case (r_state)
            S_RD: o_mem_addr = r_src + w_off;
            S_WR: begin
                o_mem_addr  = r_dst + w_off;
                o_mem_wr_en = !i_abort;
                o_mem_wdata = r_fill ? r_fill_val : r_hold;
            end
            default: ;
        endcase
    end

    assign o_busy = (r_state == S_RD) || (r_state == S_WR);
    assign o_done = (r_state == S_FIN);

endmodule

// File: tb/tb_dma_copy.sv
// Self-checking bench for dma_copy: a 256-byte memory model plus a memmove/fill reference.
// Each scenario task drives one transfer and compares timing, write count and memory contents.
module tb_dma_copy;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, fill, abort;
    logic [7:0] src, dst, len, fill_val;
    logic [7:0] mem_rdata, mem_addr, mem_wdata;
    logic       mem_wr_en, busy, done;

    logic [7:0] mem     [256];
    logic [7:0] exp_mem [256];

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int busy_cnt;
        int last_busy;
        int done_cyc;
        int done_cnt;
        int wr_cnt;
        int first_wr;
        int both;
    } obs_t;

    always #5 clk = ~clk;

    dma_copy #(.AW(8), .DW(8)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_start    (start),
        .i_fill     (fill),
        .i_src      (src),
        .i_dst      (dst),
        .i_len      (len),
        .i_fill_val (fill_val),
        .i_abort    (abort),
        .i_mem_rdata(mem_rdata),
        .o_mem_addr (mem_addr),
        .o_mem_wr_en(mem_wr_en),
        .o_mem_wdata(mem_wdata),
        .o_busy     (busy),
        .o_done     (done)
    );

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_wr_en) mem[mem_addr] <= mem_wdata;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int mem_diff();
        for (int a = 0; a < 256; a++)
            if (mem[a] !== exp_mem[a]) return a;
        return -1;
    endfunction

    task automatic poke(input logic [7:0] a, input logic [7:0] v);
        mem[a]     = v;
        exp_mem[a] = v;
    endtask

    // Reference: a snapshot of the source bytes, then the destination written in full.
    task automatic model_op(input bit f, input logic [7:0] s, input logic [7:0] d,
                            input logic [7:0] l, input logic [7:0] v);
        logic [7:0] snap [256];
        for (int o = 0; o < int'(l); o++) snap[o] = exp_mem[8'(s + 8'(o))];
        for (int o = 0; o < int'(l); o++) exp_mem[8'(d + 8'(o))] = f ? v : snap[o];
    endtask

    // Starts one transfer (start sampled at edge k) and observes cycles k+1 .. k+n_cyc.
    task automatic run_op(input bit f, input logic [7:0] s, input logic [7:0] d,
                          input logic [7:0] l, input logic [7:0] v, input int n_cyc,
                          input int abort_cyc, input int restart_cyc, output obs_t o);
        o = '{default: 0};
        o.done_cyc = -1;
        o.first_wr = -1;
        fill = f; src = s; dst = d; len = l; fill_val = v; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= n_cyc; c++) begin
            abort = (c == abort_cyc);
            if (c == restart_cyc) begin
                start = 1'b1; src = s + 8'h33; dst = d + 8'h55; len = 8'd3; fill = !f;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (busy) begin o.busy_cnt++; o.last_busy = c; end
            if (done) begin o.done_cnt++; if (o.done_cyc < 0) o.done_cyc = c; end
            if (busy && done) o.both++;
            if (mem_wr_en) begin o.wr_cnt++; if (o.first_wr < 0) o.first_wr = int'(mem_addr); end
            @(posedge clk); #1;
        end
        abort = 1'b0;
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 0; fill = 0; abort = 0;
        src = 0; dst = 0; len = 0; fill_val = 0;
        for (int a = 0; a < 256; a++) poke(8'(a), 8'($urandom));
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, mem_wr_en, mem_addr, mem_wdata} !== 19'd0) begin
            failures++;
            $display("FAIL reset_outputs: got busy=%b done=%b we=%b addr=%h wdata=%h want all 0",
                     busy, done, mem_wr_en, mem_addr, mem_wdata);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_ascending();
        obs_t o;
        poke(8'h10, 8'hAA); poke(8'h11, 8'hBB); poke(8'h12, 8'hCC); poke(8'h13, 8'hDD);
        model_op(1'b0, 8'h10, 8'h40, 8'd4, 8'h00);
        run_op(1'b0, 8'h10, 8'h40, 8'd4, 8'h00, 11, 0, 0, o);
        checks++;
        if (o.busy_cnt != 8 || o.last_busy != 8) begin
            failures++; $display("FAIL asc_busy: got cnt=%0d last=%0d want 8/8", o.busy_cnt, o.last_busy);
        end
        checks++;
        if (o.done_cyc != 9 || o.done_cnt != 1) begin
            failures++; $display("FAIL asc_done: got cyc=%0d cnt=%0d want 9/1", o.done_cyc, o.done_cnt);
        end
        checks++;
        if (o.first_wr != 'h40) begin
            failures++; $display("FAIL asc_first_wr: got %h want 40", o.first_wr);
        end
        checks++;
        if (mem[8'h43] !== 8'hDD || mem[8'h10] !== 8'hAA) begin
            failures++; $display("FAIL asc_bytes: got m43=%h m10=%h want DD/AA", mem[8'h43], mem[8'h10]);
        end
        checks++;
        if (mem_diff() >= 0) begin
            failures++; $display("FAIL asc_mem: got mismatch at %h want none", mem_diff());
        end
    endtask

    task automatic test_overlap();
        obs_t o;
        for (int k = 0; k < 5; k++) poke(8'(8'h20 + k), 8'(k + 1));
        model_op(1'b0, 8'h20, 8'h22, 8'd5, 8'h00);
        run_op(1'b0, 8'h20, 8'h22, 8'd5, 8'h00, 13, 0, 0, o);
        checks++;
        if (o.first_wr != 'h26) begin
            failures++; $display("FAIL ovl_first_wr: got %h want 26", o.first_wr);
        end
        checks++;
        if (mem[8'h22] !== 8'h01 || mem[8'h26] !== 8'h05 || mem[8'h20] !== 8'h01 || mem[8'h21] !== 8'h02) begin
            failures++;
            $display("FAIL ovl_bytes: got m20=%h m21=%h m22=%h m26=%h want 01/02/01/05",
                     mem[8'h20], mem[8'h21], mem[8'h22], mem[8'h26]);
        end
        checks++;
        if (o.done_cyc != 11 || o.wr_cnt != 5) begin
            failures++; $display("FAIL ovl_timing: got done=%0d wr=%0d want 11/5", o.done_cyc, o.wr_cnt);
        end
        checks++;
        if (mem_diff() >= 0) begin
            failures++; $display("FAIL ovl_mem: got mismatch at %h want none", mem_diff());
        end
    endtask

    task automatic test_wrap_fill();
        obs_t o;
        model_op(1'b1, 8'h00, 8'hFE, 8'd4, 8'h5A);
        run_op(1'b1, 8'h00, 8'hFE, 8'd4, 8'h5A, 7, 0, 0, o);
        checks++;
        if (o.busy_cnt != 4 || o.done_cyc != 5 || o.both != 0) begin
            failures++;
            $display("FAIL fill_timing: got busy=%0d done=%0d both=%0d want 4/5/0", o.busy_cnt, o.done_cyc, o.both);
        end
        checks++;
        if (mem[8'hFF] !== 8'h5A || mem[8'h00] !== 8'h5A || mem[8'h01] !== 8'h5A) begin
            failures++; $display("FAIL fill_wrap: got ff=%h 00=%h 01=%h want 5A", mem[8'hFF], mem[8'h00], mem[8'h01]);
        end
        checks++;
        if (mem_diff() >= 0) begin
            failures++; $display("FAIL fill_mem: got mismatch at %h want none", mem_diff());
        end
    endtask

    task automatic test_zero_len();
        obs_t o;
        run_op(1'b0, 8'h12, 8'h34, 8'd0, 8'h00, 3, 0, 0, o);
        checks++;
        if (o.wr_cnt != 0 || o.busy_cnt != 0) begin
            failures++; $display("FAIL zero_activity: got wr=%0d busy=%0d want 0/0", o.wr_cnt, o.busy_cnt);
        end
        checks++;
        if (o.done_cyc != 1 || o.done_cnt != 1) begin
            failures++; $display("FAIL zero_done: got cyc=%0d cnt=%0d want 1/1", o.done_cyc, o.done_cnt);
        end
    endtask

    task automatic test_abort();
        obs_t o;
        model_op(1'b0, 8'h80, 8'hA0, 8'd2, 8'h00);
        run_op(1'b0, 8'h80, 8'hA0, 8'd6, 8'h00, 9, 6, 0, o);
        checks++;
        if (o.wr_cnt != 2 || o.done_cnt != 0) begin
            failures++; $display("FAIL abort_writes: got wr=%0d done=%0d want 2/0", o.wr_cnt, o.done_cnt);
        end
        checks++;
        if (o.busy_cnt != 6 || o.last_busy != 6) begin
            failures++; $display("FAIL abort_idle: got busy=%0d last=%0d want 6/6", o.busy_cnt, o.last_busy);
        end
        checks++;
        if (mem_diff() >= 0) begin
            failures++; $display("FAIL abort_mem: got mismatch at %h want none", mem_diff());
        end
        model_op(1'b0, 8'h90, 8'h10, 8'd3, 8'h00);
        run_op(1'b0, 8'h90, 8'h10, 8'd3, 8'h00, 9, 0, 0, o);
        checks++;
        if (o.done_cyc != 7 || o.wr_cnt != 3 || mem_diff() >= 0) begin
            failures++; $display("FAIL abort_restart: got done=%0d wr=%0d diff=%0d want 7/3/-1",
                                 o.done_cyc, o.wr_cnt, mem_diff());
        end
    endtask

    task automatic test_start_busy();
        obs_t o;
        model_op(1'b0, 8'h30, 8'h60, 8'd10, 8'h00);
        run_op(1'b0, 8'h30, 8'h60, 8'd10, 8'h00, 23, 0, 3, o);
        checks++;
        if (o.busy_cnt != 20 || o.done_cyc != 21 || o.wr_cnt != 10) begin
            failures++; $display("FAIL busy_start_timing: got busy=%0d done=%0d wr=%0d want 20/21/10",
                                 o.busy_cnt, o.done_cyc, o.wr_cnt);
        end
        checks++;
        if (mem_diff() >= 0) begin
            failures++; $display("FAIL busy_start_mem: got mismatch at %h want none", mem_diff());
        end
    endtask

    task automatic test_reset_mid();
        int done_seen = 0;
        fill = 1'b0; src = 8'h05; dst = 8'hC0; len = 8'd6; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (mem_wr_en !== 1'b1) begin
            failures++; $display("FAIL rst_pre_we: got %b want 1", mem_wr_en);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, mem_wr_en, mem_addr, mem_wdata} !== 19'd0) begin
            failures++;
            $display("FAIL rst_mid_outputs: got busy=%b done=%b we=%b addr=%h wdata=%h want all 0",
                     busy, done, mem_wr_en, mem_addr, mem_wdata);
        end
        #3 rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (done || busy) done_seen++;
        end
        checks++;
        if (done_seen != 0 || mem_diff() >= 0) begin
            failures++; $display("FAIL rst_mid_after: got activity=%0d diff=%0d want 0/-1", done_seen, mem_diff());
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        obs_t o;
        bit         f;
        logic [7:0] s, d, l, v;
        int         exp_done;
        for (int n = 0; n < 20; n++) begin
            f = 1'($urandom_range(0, 1));
            s = 8'($urandom);
            d = 8'($urandom);
            l = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 128));
            v = 8'($urandom);
            exp_done = (l == 0) ? 1 : (f ? int'(l) + 1 : 2 * int'(l) + 1);
            model_op(f, s, d, l, v);
            run_op(f, s, d, l, v, exp_done + 2, 0, 0, o);
            checks++;
            if (o.done_cyc != exp_done || o.done_cnt != 1 || o.busy_cnt != exp_done - 1 || o.both != 0) begin
                failures++;
                $display("FAIL rand%0d_timing: got done=%0d cnt=%0d busy=%0d both=%0d want %0d/1/%0d/0",
                         n, o.done_cyc, o.done_cnt, o.busy_cnt, o.both, exp_done, exp_done - 1);
            end
            checks++;
            if (o.wr_cnt != int'(l) || mem_diff() >= 0) begin
                failures++; $display("FAIL rand%0d_mem: got wr=%0d diff=%0d want %0d/-1", n, o.wr_cnt, mem_diff(), l);
            end
        end
    endtask

    initial begin
        test_reset();
        test_ascending();
        test_overlap();
        test_wrap_fill();
        test_zero_len();
        test_abort();
        test_start_busy();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dma_copy.md
# dma_copy

Byte-block copy/fill engine sitting directly upstream of the 8-bit × 256-word data memory. The engine drives the memory's address, write-enable and write-data inputs, and consumes its combinational read data. It moves `len` bytes from `src` to `dst` with memmove semantics, or fills `len` bytes at `dst` with a constant. Top-level muxing gives it the memory port whenever `busy` is high.

## Interface
- `AW`, default 8: address width; the memory has 2^AW words, and all address arithmetic is modulo 2^AW.
- `DW`, default 8: data width.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, asynchronous and active-low. One clock; no other reset.
- `start`  in  1  request; sampled only in IDLE.
- `fill`  in  1  0 = copy, 1 = fill; latched at start.
- `src`  in  AW  source base address; latched at start; ignored in fill mode.
- `dst`  in  AW  destination base address; latched at start.
- `len`  in  AW  byte count 0..255; latched at start.
- `fill_val`  in  DW  fill byte; latched at start.
- `abort`  in  1  synchronous cancel; effective in any busy state.
- `mem_rdata`  in  DW  memory read data, valid in the same cycle as `mem_addr`.
- `mem_addr`  out  AW  memory address.
- `mem_wr_en`  out  1  memory write enable.
- `mem_wdata`  out  DW  memory write data.
- `busy`  out  1  engine owns the memory port.
- `done`  out  1  single-cycle completion pulse.

## Operation
- States: IDLE, RD, WR, FIN.
- Registers: latched `fill`, `src`, `dst`, `len`, `fill_val`; `dir` (0 = ascending, 1 = descending); index `i` (AW bits); `hold` (DW bits).

Start (IDLE with `start`=1):
- `len`=0: go to FIN. No memory access occurs.
- Otherwise: latch the inputs and set `i`=0.
  - Copy mode: go to RD.
  - Fill mode: go to WR.
- Set `dir`=1 if and only if all hold: copy mode, `dst`≠`src`, and ((`dst`−`src`) mod 256) < `len`. In that case the destination overlaps the tail of the source.

Offsets and addresses:
- Offset `o` = `i` when ascending; `len`−1−`i` when descending.
- Source address = (`src`+`o`) mod 256. Destination address = (`dst`+`o`) mod 256.

RD state:
- Drive `mem_addr` = source address, `mem_wr_en`=0.
- Capture `mem_rdata` into `hold` at the clock edge.
- Next state: WR.

WR state:
- Drive `mem_addr` = destination address and `mem_wr_en`=1.
- `mem_wdata` = `hold` in copy mode; latched `fill_val` in fill mode.
- If `i`=`len`−1, go to FIN.
- Otherwise increment `i` and go to RD (copy) or stay in WR (fill).

FIN state:
- `done`=1 for one cycle, then go to IDLE.

Abort:
- `abort`=1 in RD or WR: the WR write of that same cycle is suppressed (`mem_wr_en` forced to 0).
- Next state is IDLE. No `done` pulse is issued.
- Bytes already written remain written.

Other rules:
- `start` asserted outside IDLE is ignored and is not queued.
- `abort` asserted in IDLE or FIN has no effect.
- In IDLE and FIN: `mem_addr`=0, `mem_wr_en`=0, `mem_wdata`=0.
- Outputs are decoded combinationally from registered state only; there is no input-to-output combinational path except through `abort` gating `mem_wr_en`.

## Timing
- Reset values: state = IDLE, all outputs 0, `hold`=0, `i`=0.
- Reset asserted mid-transfer returns to IDLE immediately. `mem_wr_en` drops asynchronously and no `done` pulse is issued.
- With `start` sampled at edge k:
  - Copy of N bytes: `busy` is high for cycles k+1 .. k+2N; `done` is high in cycle k+2N+1.
  - Fill of N bytes: `busy` is high for cycles k+1 .. k+N; `done` is high in cycle k+N+1.
  - `len`=0: `done` is high in cycle k+1; `busy` is never asserted.
- `busy`=1 exactly in the RD and WR states. `busy` and `done` are never high together.
- A new `start` is accepted in the cycle after FIN, at the earliest.
- The memory write commits on the rising edge that ends each WR cycle.

## Test plan
- **Ascending copy:** preload mem[0x10..0x13]=AA,BB,CC,DD; copy `src`=0x10, `dst`=0x40, `len`=4.
  - Required: mem[0x40..0x43]=AA,BB,CC,DD.
  - Required: `busy` high for 8 cycles; `done` 1 cycle later; source bytes unchanged.
- **Overlap, descending:** preload mem[0x20..0x24]=01..05; copy `src`=0x20, `dst`=0x22, `len`=5.
  - Required: `dir`=1.
  - Required: mem[0x22..0x26]=01,02,03,04,05; mem[0x20..0x21] unchanged.
  - Required: first write address is 0x26.
- **Wrap-around fill:** fill `dst`=0xFE, `len`=4, `fill_val`=5A.
  - Required: mem[0xFE], mem[0xFF], mem[0x00], mem[0x01] = 5A.
  - Required: `busy` high 4 cycles; `done` follows.
- **Zero length:** `len`=0 with `start`.
  - Required: no `mem_wr_en` pulse; `done` in cycle k+1; `busy` stays 0.
- **Abort:** during a 6-byte copy, assert `abort` in the WR cycle of byte 2 (0-based).
  - Required: only bytes 0 and 1 are written; no `done`.
  - Required: IDLE next cycle; a fresh `start` then works normally.
- **Start while busy; reset mid-operation:**
  - `start` pulsed while `busy`=1 is ignored: the transfer length and addresses are unchanged.
  - `rst_n` low during WR: `mem_wr_en` drops to 0 immediately and all outputs read 0.
